// File: rtl/upcounter_ctrl.sv
// -----------------------------------------------------------------------------
// upcounter_ctrl
//   Sequencing controller for the DFF-based up-counter datapath. It owns the
//   count register and decides each cycle whether the count clears, loads,
//   increments or holds. It also provides start/pause/clear/load control, a
//   programmable terminal count, one-shot or auto-reload operation, and
//   single-cycle done/ovf pulses.
//
//   Optional feature macro: UPCNT_PRESCALE_EN
//     defined   : in RUN, the count advances once every PRESCALE cycles. The
//                 phase is held in a small prescaler counter.
//     undefined : the count advances on every RUN cycle. No prescaler
//                 hardware is built.
//
//   Every output comes straight from a flop. busy is registered together
//   with the state so that it always matches the state register.
// -----------------------------------------------------------------------------
module upcounter_ctrl #(
    parameter int W        = 4,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    // Controller states, 2-bit encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]   state_q,  state_d;
    logic [W-1:0] count_q,  count_d;
    logic [W-1:0] term_q,   term_d;
    logic         reload_q, reload_d;
    logic         busy_q,   busy_d;
    logic         done_q,   done_d;
    logic         ovf_q,    ovf_d;

    // tick qualifies a RUN cycle as a counting cycle
    logic         tick;

`ifdef UPCNT_PRESCALE_EN
    // With PRESCALE=1 the prescaler stays at 0, so it ticks on every cycle.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] psc_q, psc_d;
    logic          launch;
    logic          advance;

    assign tick = (psc_q == PW'(PRESCALE - 1));

    // A start from IDLE or DONE restarts the tick phase at zero.
    assign launch  = (state_d == S_RUN) && ((state_q == S_IDLE) || (state_q == S_DONE));
    // The phase only moves on RUN cycles that do not pause. HOLD freezes it,
    // so counting picks up the same phase when RUN resumes.
    assign advance = (state_q == S_RUN) && !clear && !pause;

    // Prescaler next phase: clear/launch reset it, RUN cycles advance and wrap it.
    always_comb begin
        psc_d = psc_q;
        if (clear || launch) begin
            psc_d = '0;
        end else if (advance) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
    end

    // Prescaler phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    // Every RUN cycle is a tick. PRESCALE only has to be a legal value here.
    localparam bit PRESCALE_OK = (PRESCALE >= 1);
    assign tick = PRESCALE_OK;
`endif

    // Decide the next state, count and pulses, in priority order clear > load > start > pause.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        term_d   = term_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;

        if (clear) begin
            // Clear from any state goes straight to IDLE and does not pulse.
            state_d = S_IDLE;
            count_d = '0;
        end else if (load && ((state_q == S_IDLE) || (state_q == S_HOLD))) begin
            count_d = load_val;
            // A start with a load in IDLE begins counting from the loaded value.
            // In HOLD the load wins over the pause release, so the state stays put.
            if ((state_q == S_IDLE) && start) begin
                state_d  = S_RUN;
                term_d   = term_val;
                reload_d = auto_reload;
            end
        end else begin
            // A load in RUN or DONE is ignored and normal sequencing applies.
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_RUN;
                        term_d   = term_val;
                        reload_d = auto_reload;
                    end
                end
                S_RUN: begin
                    // start is ignored here, so a running count cannot be restarted.
                    if (pause) begin
                        state_d = S_HOLD;
                    end else if (tick) begin
                        // The compare uses the pre-increment count, so a terminal
                        // value of 0 finishes on the first tick.
                        if (count_q == term_q) begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            // If the count starts above term_q, it wraps through
                            // all-ones before it can reach the terminal value.
                            ovf_d   = &count_q;
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // The count is frozen. start is ignored and only the pause
                    // release leaves HOLD.
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d  = S_RUN;
                        count_d  = '0;
                        term_d   = term_val;
                        reload_d = auto_reload;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    // Controller and count registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            term_q   <= '0;
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            term_q   <= term_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_upcounter_ctrl
//   Scoreboard bench for upcounter_ctrl. The stimulus side drives one cycle at
//   a time. It advances a behavioural model of the counter rules and queues
//   the outputs expected after that edge. A separate monitor pops and compares
//   them on every falling edge. A short directed section reproduces the
//   documented scenarios, and a randomized section follows it.
// -----------------------------------------------------------------------------
module tb_upcounter_ctrl;

    localparam int W        = 4;
    localparam int PRESCALE = 4;
    localparam int MODV     = 1 << W;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         ovf;
        logic [W-1:0] count;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, pause, clear, load, auto_reload;
    logic [W-1:0] load_val, term_val;
    logic [W-1:0] count;
    logic         busy, done, ovf;

    always #5 clk = ~clk;

    upcounter_ctrl #(.W(W), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .load(load), .load_val(load_val), .term_val(term_val),
        .auto_reload(auto_reload), .count(count), .busy(busy), .done(done),
        .ovf(ovf)
    );

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
    int m_mode, m_cnt, m_term, m_phase;
    bit m_rl, m_done, m_ovf;

    function automatic void model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_term = 0; m_rl = 0;
        m_phase = 0; m_done = 0; m_ovf = 0;
    endfunction

    function automatic void model_begin(int tv, bit ar);
        m_mode = M_RUN; m_term = tv; m_rl = ar; m_phase = 0;
    endfunction

    // One clock edge of the counter rules, for the given inputs
    function automatic void model_step(bit s, bit p, bit c, bit l, int lv, int tv, bit ar);
        bit t;
        m_done = 0; m_ovf = 0;
        if (c) begin
            m_mode = M_IDLE; m_cnt = 0; m_phase = 0;
        end else if (l && (m_mode == M_IDLE || m_mode == M_HOLD)) begin
            m_cnt = lv;
            if (m_mode == M_IDLE && s) model_begin(tv, ar);
        end else if (m_mode == M_IDLE) begin
            if (s) model_begin(tv, ar);
        end else if (m_mode == M_DONE) begin
            if (s) begin model_begin(tv, ar); m_cnt = 0; end
        end else if (m_mode == M_HOLD) begin
            if (!p) m_mode = M_RUN;
        end else begin
            if (p) m_mode = M_HOLD;
            else begin
`ifdef UPCNT_PRESCALE_EN
                t = (m_phase == PRESCALE - 1);
                m_phase = t ? 0 : m_phase + 1;
`else
                t = 1;
`endif
                if (t) begin
                    if (m_cnt == m_term) begin
                        m_done = 1;
                        if (m_rl) m_cnt = 0;
                        else m_mode = M_DONE;
                    end else begin
                        m_ovf = (m_cnt == MODV - 1);
                        m_cnt = (m_cnt + 1) % MODV;
                    end
                end
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.busy  = (m_mode == M_RUN) || (m_mode == M_HOLD);
        o.done  = m_done;
        o.ovf   = m_ovf;
        o.count = m_cnt[W-1:0];
        return o;
    endfunction

    function automatic obs_t mk(bit b, bit d, bit o, int c);
        obs_t r;
        r.busy = b; r.done = d; r.ovf = o; r.count = c[W-1:0];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input bit p, input bit c, input bit l,
                        input int lv, input int tv, input bit ar);
        @(negedge clk);
        start = s; pause = p; clear = c; load = l;
        load_val = lv[W-1:0]; term_val = tv[W-1:0]; auto_reload = ar;
        model_step(s, p, c, l, lv, tv, ar);
        @(posedge clk);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Direct sample-and-compare, used right after a step or reset
    task automatic check_now(input string name, input obs_t e);
        obs_t a;
        #1;
        a = {busy, done, ovf, count};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got busy=%b done=%b ovf=%b count=%0d, expected busy=%b done=%b ovf=%b count=%0d",
                     name, a.busy, a.done, a.ovf, a.count, e.busy, e.done, e.ovf, e.count);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    obs_t mon_e, mon_a;
    int   mon_cycle = 0;
    initial begin
        forever begin
            @(negedge clk);
            mon_cycle++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {busy, done, ovf, count};
                vectors++;
                if (mon_a !== mon_e) begin
                    miscompares++;
                    $display("FAIL scoreboard cycle %0d: got busy=%b done=%b ovf=%b count=%0d, expected busy=%b done=%b ovf=%b count=%0d",
                             mon_cycle, mon_a.busy, mon_a.done, mon_a.ovf, mon_a.count,
                             mon_e.busy, mon_e.done, mon_e.ovf, mon_e.count);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        start = 0; pause = 0; clear = 0; load = 0; auto_reload = 0;
        load_val = '0; term_val = '0;
        model_reset();
        check_now("reset_state", mk(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // One-shot to terminal 5
        step(1, 0, 0, 0, 0, 5, 0);
        repeat (5) idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("oneshot_at5", mk(1, 0, 0, 5));
`endif
        idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("oneshot_done", mk(0, 1, 0, 5));
`endif
        idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("oneshot_hold", mk(0, 0, 0, 5));
`endif
        // Restart from DONE clears the count
        step(1, 0, 0, 0, 0, 3, 0);
`ifndef UPCNT_PRESCALE_EN
        check_now("restart_from_done", mk(1, 0, 0, 0));
`endif

        // Auto-reload with terminal 2
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 2, 1);
        repeat (3) idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("reload_wrap", mk(1, 1, 0, 0));
`endif
        repeat (3) idle_step();

        // Load above terminal, wrap through overflow
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 14, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 9, 1);   // changed term/reload after start have no effect
        idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("ovf_wrap", mk(1, 0, 1, 0));
`endif
        repeat (2) idle_step();

        // Pause/hold, start ignored in HOLD, then clear+load together
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 0);
        repeat (2) idle_step();
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
`ifndef UPCNT_PRESCALE_EN
        check_now("hold_frozen", mk(1, 0, 0, 2));
`endif
        repeat (2) idle_step();
`ifndef UPCNT_PRESCALE_EN
        check_now("hold_resume", mk(1, 0, 0, 3));
`endif
        step(0, 0, 1, 1, 7, 0, 0);
        check_now("clear_over_load", mk(0, 0, 0, 0));

        // Asynchronous reset mid-RUN
        step(1, 0, 0, 0, 0, 9, 0);
        repeat (3) idle_step();
        @(negedge clk);
        #2 rst = 1'b1;
        check_now("async_reset", mk(0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 40) == 0,
                 ($urandom % 10) == 0, int'($urandom % MODV),
                 int'($urandom % MODV), ($urandom % 2) == 1);
        end

        // Let the monitor drain the queue, with a bounded wait
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
